rr_mux_arb: RTL and testbench
=============================

RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 2, giving the width of each source data slot and of out_data.
REQ-002 The block SHALL have a fixed source count of 4, with source index i in 0..3.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-005 Port req, input, 4 bits, SHALL carry source request lines; req[i] high means source i has data.
REQ-006 Port din, input, 4*DATA_W bits, SHALL carry source data; slot i is din[DATA_W*(i+1)-1 : DATA_W*i].
REQ-007 Port gnt, output, 4 bits, SHALL be the one-hot grant, all-zero when nothing is granted.
REQ-008 Port out_sel, output, 2 bits, SHALL be the binary index of the granted source.
REQ-009 Port out_data, output, DATA_W bits, SHALL be the captured data of the granted source.
REQ-010 Port out_valid, output, 1 bit, SHALL be high while out_data holds an untransferred item.
REQ-011 Port out_ready, input, 1 bit, SHALL be the downstream accept; transfer = out_valid & out_ready.

Function
REQ-012 The block SHALL implement states IDLE (out_valid=0) and BUSY (out_valid=1) only.
REQ-013 The block SHALL hold a 2-bit priority pointer ptr; search order SHALL be ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-014 In IDLE, with any req bit high at edge t, the block SHALL select the first requesting index w in search order and enter BUSY.
REQ-015 On that edge it SHALL set gnt=1<<w and out_sel=w, and capture din slot w into out_data; out_valid SHALL be high from cycle t+1.
REQ-016 In IDLE with req=0, all outputs SHALL hold and gnt SHALL remain 0.
REQ-017 In BUSY without transfer, gnt, out_sel, out_data and out_valid SHALL stay constant regardless of req/din changes.
REQ-018 On a transfer edge, ptr SHALL become out_sel+1 (mod 4), wrapping 3->0.
REQ-019 On a transfer edge with any req bit high, the block SHALL rearbitrate using the updated ptr and remain in BUSY with the new grant and data, giving back-to-back throughput of one item per cycle.
REQ-020 On a transfer edge with req=0, the block SHALL return to IDLE, clear gnt, and hold out_sel and out_data.
REQ-021 A source whose gnt bit is high during a transfer cycle SHALL treat that cycle as consumption of its item; if it keeps req high, it is rearbitrated as a new request at lowest priority.
REQ-022 gnt SHALL never have more than one bit set; gnt SHALL be nonzero iff out_valid=1.
REQ-023 The block SHALL never drop or duplicate an item: exactly one transfer per grant.
REQ-024 Within any window of 4 consecutive transfers, each continuously requesting source SHALL be granted at least once.
REQ-025 ptr SHALL change only on transfer edges.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set state=IDLE, ptr=0, gnt=0, out_sel=0, out_data=0, out_valid=0, overriding all other inputs.
REQ-027 Reset asserted in BUSY SHALL discard the pending item without a transfer; the first grant after reset SHALL follow REQ-014 with ptr=0.

Verification
REQ-028 Reset then req=4'b1111, out_ready=1, din slots 0..3=0,1,2,3 -> out_sel sequence 0,1,2,3,0,... one per cycle starting cycle 1 after req; out_data equals out_sel.
REQ-029 IDLE, req=4'b0100, din slot2=2'b10, out_ready=0 for 3 cycles -> out_valid, gnt=4'b0100 and out_data=2'b10 stable for all 3 cycles; din changed mid-hold does not alter out_data.
REQ-030 After a transfer from source 3 (ptr wraps to 0), req=4'b1001 -> next grant is source 0, then source 3.
REQ-031 Single transfer from source 1 with req dropped to 0 on the transfer edge -> IDLE next cycle, out_valid=0, gnt=0.
REQ-032 rst=1 pulsed while BUSY with out_ready=0 -> all outputs 0 next cycle; with req=4'b0010 the next grant is source 1 and ptr starts from 0.

Source files
------------

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: 4-source round-robin arbiter that captures the winner's data into a
// single valid/ready output register. Rev 1.0

`default_nettype none

module rr_mux_arb #(
  parameter int DATA_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   din,
  output logic [3:0]            gnt,
  output logic [1:0]            out_sel,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_ptr, w_ptr_nxt;
  logic [3:0]          r_gnt, w_gnt_nxt;
  logic [1:0]          r_sel, w_sel_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;

  logic                w_xfer;
  logic [1:0]          w_base;
  logic [1:0]          w_win;
  logic                w_found;
  logic [1:0]          w_idx;

  assign w_xfer = (r_state == BUSY) && out_ready;

  // A transfer moves priority past the item just consumed, so the rearbitration
  // on that same edge already sees the updated pointer.
  assign w_base = w_xfer ? (r_sel + 2'd1) : r_ptr;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = w_base;
    w_idx   = w_base;
    for (int k = 3; k >= 0; k--) begin
      w_idx = w_base + 2'(k);
      if (req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_data_nxt  = r_data;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = BUSY;
          w_gnt_nxt   = 4'b0001 << w_win;
          w_sel_nxt   = w_win;
          w_data_nxt  = din[DATA_W*w_win +: DATA_W];
        end
      end
      BUSY: begin
        if (w_xfer) begin
          w_ptr_nxt = r_sel + 2'd1;
          if (w_found) begin
            w_gnt_nxt  = 4'b0001 << w_win;
            w_sel_nxt  = w_win;
            w_data_nxt = din[DATA_W*w_win +: DATA_W];
          end else begin
            // Drained: sel/data stay as the last delivered item.
            w_state_nxt = IDLE;
            w_gnt_nxt   = 4'b0000;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign out_sel   = r_sel;
  assign out_data  = r_data;
  assign out_valid = (r_state == BUSY);

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: directed and randomized checks of rr_mux_arb against an
// in-bench round-robin model. Rev 1.0

`default_nettype none

module tb_rr_mux_arb;

  localparam int DATA_W = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [3:0]          req;
  logic [4*DATA_W-1:0] din;
  logic [3:0]          gnt;
  logic [1:0]          out_sel;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  // Model state: pending item (valid/source/data) and the round-robin pointer.
  int m_valid = 0;
  int m_sel   = 0;
  int m_data  = 0;
  int m_ptr   = 0;

  rr_mux_arb #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .out_sel   (out_sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int slot(input logic [4*DATA_W-1:0] d, input int i);
    return int'((d >> (DATA_W * i)) & ((1 << DATA_W) - 1));
  endfunction

  // Reference: priority order is ptr, ptr+1, ... mod 4; a transfer consumes the
  // pending item and advances ptr past it before the next pick.
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 0; m_sel = 0; m_data = 0; m_ptr = 0;
    end else begin
      bit xfer;
      bit found;
      int w;
      xfer  = (m_valid != 0) && out_ready;
      found = 1'b0;
      w     = 0;
      if (xfer) m_ptr = (m_sel + 1) % 4;
      if (m_valid == 0 || xfer) begin
        for (int k = 0; k < 4; k++) begin
          if (!found && req[(m_ptr + k) % 4]) begin
            found = 1'b1;
            w     = (m_ptr + k) % 4;
          end
        end
        if (found) begin
          m_valid = 1; m_sel = w; m_data = slot(din, w);
        end else if (xfer) begin
          m_valid = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", 32'(out_valid), 32'(m_valid));
      chk("m_gnt",   32'(gnt), (m_valid != 0) ? (32'd1 << m_sel) : 32'd0);
      chk("m_sel",   32'(out_sel), 32'(m_sel));
      chk("m_data",  32'(out_data), 32'(m_data));
    end
  end

  task automatic expect_out(input string nm, input logic v, input logic [3:0] g,
                            input logic [1:0] s, input logic [1:0] d);
    chk({nm, "_valid"}, 32'(out_valid), 32'(v));
    chk({nm, "_gnt"},   32'(gnt),       32'(g));
    chk({nm, "_sel"},   32'(out_sel),   32'(s));
    chk({nm, "_data"},  32'(out_data),  32'(d));
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; din = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_out("reset", 1'b0, 4'b0000, 2'd0, 2'd0);
    chk_en = 1'b1;

    // Full request set rotates 0,1,2,3; data mirrors the index.
    rst = 1'b0; req = 4'b1111; din = 8'b11_10_01_00; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      expect_out($sformatf("rot%0d", k), 1'b1, 4'b0001 << k, 2'(k), 2'(k));
    end
    // Pointer wrapped to 0 after source 3: 0 wins, then 3.
    req = 4'b1001;
    @(negedge clk);
    expect_out("wrap0", 1'b1, 4'b0001, 2'd0, 2'd0);
    @(negedge clk);
    expect_out("wrap3", 1'b1, 4'b1000, 2'd3, 2'd3);
    req = 4'b0000;
    @(negedge clk);
    expect_out("drain", 1'b0, 4'b0000, 2'd3, 2'd3);

    // Stall holds grant and captured data even when din changes.
    req = 4'b0100; din = 8'b00_10_00_00; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      expect_out($sformatf("hold%0d", k), 1'b1, 4'b0100, 2'd2, 2'b10);
      din = 8'b11_01_11_11;
    end
    out_ready = 1'b1; req = 4'b0000;
    @(negedge clk);
    expect_out("hold_done", 1'b0, 4'b0000, 2'd2, 2'b10);

    // ptr=3: source 1 wins, single transfer back to IDLE.
    req = 4'b0010; din = 8'b00_00_10_00; out_ready = 1'b0;
    @(negedge clk);
    expect_out("src1", 1'b1, 4'b0010, 2'd1, 2'b10);
    out_ready = 1'b1; req = 4'b0000;
    @(negedge clk);
    expect_out("src1_idle", 1'b0, 4'b0000, 2'd1, 2'b10);

    // ptr=2 now; reset while BUSY must discard the item and restore ptr=0.
    req = 4'b0001; din = 8'b00_00_00_11; out_ready = 1'b0;
    @(negedge clk);
    expect_out("pre_rst", 1'b1, 4'b0001, 2'd0, 2'd3);
    rst = 1'b1;
    @(negedge clk);
    expect_out("mid_rst", 1'b0, 4'b0000, 2'd0, 2'd0);
    rst = 1'b0; req = 4'b1110; din = 8'b00_00_01_00;
    @(negedge clk);
    expect_out("post_rst", 1'b1, 4'b0010, 2'd1, 2'd1);
    out_ready = 1'b1; req = 4'b0000;
    @(negedge clk);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      req       = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
      din       = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
